// File: rtl/usb4_sb_pkg.sv
// Shared sideband definitions: CRC-16 constants and the transmit FSM state type.
// The receive-side checker uses the same constants, so the LFSR seed and polynomial stay in step.
package usb4_sb_pkg;

  localparam logic [15:0] CRC16_POLY  = 16'h8005;
  localparam logic [15:0] CRC16_SEED  = 16'hFFFF;
  localparam logic [15:0] CRC16_CHECK = 16'hAEE7;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_DATA = 2'd1,
    TX_CRC  = 2'd2,
    TX_END  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/crc_16_lfsr_step.sv
// One-bit CRC-16 LFSR advance, MSB-first, no reflection.
// Shared with the receiver so both sides compute identical residues.
module crc_16_lfsr_step
  import usb4_sb_pkg::*;
(
  input  logic [15:0] i_lfsr,
  input  logic        i_bit,
  output logic [15:0] o_lfsr
);

  logic w_fb;

  assign w_fb   = i_bit ^ i_lfsr[15];
  assign o_lfsr = {i_lfsr[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);

endmodule

// File: rtl/crc_16_trans.sv
// Sideband transmit CRC-16 serializer: bytes in over valid/ready, payload then CRC out MSB-first.
// state   | meaning
// IDLE    | waiting for first byte, LFSR at seed, ready high
// DATA    | shifting payload bits; ready only on the last bit of a byte
// CRC     | shifting the 16 CRC bits out of the LFSR
// END     | one crc_en-low gap cycle; raises done or abort
module crc_16_trans
  import usb4_sb_pkg::*;
#(
  parameter logic [15:0] SEED = CRC16_SEED
) (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic [7:0] i_data_in,
  input  logic       i_data_valid,
  input  logic       i_data_last,
  output logic       o_data_ready,
  output logic       o_trans_ser,
  output logic       o_crc_en,
  output logic       o_done,
  output logic       o_abort
);

  tx_state_e   r_state;
  logic [7:0]  r_sh;
  logic [2:0]  r_bit_cnt;
  logic [3:0]  r_crc_cnt;
  logic        r_last;
  logic        r_underrun;
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;
  logic        w_boundary;
  logic        w_accept;

  crc_16_lfsr_step u_lfsr_step (
    .i_lfsr (r_lfsr),
    .i_bit  (r_sh[7]),
    .o_lfsr (w_lfsr_next)
  );

  // Ready on the final bit of a byte lets the next byte load with no bubble.
  assign w_boundary   = (r_state == TX_DATA) && (r_bit_cnt == 3'd0);
  assign o_data_ready = (r_state == TX_IDLE) || (w_boundary && !r_last);
  assign w_accept     = i_data_valid && o_data_ready;

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      r_state     <= TX_IDLE;
      r_sh        <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_crc_cnt   <= 4'd0;
      r_last      <= 1'b0;
      r_underrun  <= 1'b0;
      r_lfsr      <= SEED;
      o_trans_ser <= 1'b0;
      o_crc_en    <= 1'b0;
      o_done      <= 1'b0;
      o_abort     <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      o_abort <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          o_trans_ser <= 1'b0;
          o_crc_en    <= 1'b0;
          r_lfsr      <= SEED;
          r_underrun  <= 1'b0;
          if (w_accept) begin
            r_sh      <= i_data_in;
            r_last    <= i_data_last;
            r_bit_cnt <= 3'd7;
            r_state   <= TX_DATA;
          end
        end
        TX_DATA: begin
          o_trans_ser <= r_sh[7];
          o_crc_en    <= 1'b1;
          r_lfsr      <= w_lfsr_next;
          r_sh        <= {r_sh[6:0], 1'b0};
          r_bit_cnt   <= r_bit_cnt - 3'd1;
          if (r_bit_cnt == 3'd0) begin
            if (r_last) begin
              r_crc_cnt <= 4'd15;
              r_state   <= TX_CRC;
            end else if (w_accept) begin
              r_sh      <= i_data_in;
              r_last    <= i_data_last;
              r_bit_cnt <= 3'd7;
            end else begin
              r_underrun <= 1'b1;
              r_state    <= TX_END;
            end
          end
        end
        TX_CRC: begin
          o_trans_ser <= r_lfsr[15];
          o_crc_en    <= 1'b1;
          r_lfsr      <= {r_lfsr[14:0], 1'b0};
          r_crc_cnt   <= r_crc_cnt - 4'd1;
          if (r_crc_cnt == 4'd0) r_state <= TX_END;
        end
        TX_END: begin
          o_trans_ser <= 1'b0;
          o_crc_en    <= 1'b0;
          r_lfsr      <= SEED;
          o_done      <= !r_underrun;
          o_abort     <= r_underrun;
          r_state     <= TX_IDLE;
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_16_trans.sv
// Directed/random bench for crc_16_trans with a byte-wise software CRC model and
// a behavioural receiver that checks for a zero residue over payload plus CRC.
module tb_crc_16_trans;

  typedef logic [7:0] byte_q_t[$];

  logic       sb_clk = 1'b0;
  logic       rst;
  logic [7:0] i_data_in;
  logic       i_data_valid;
  logic       i_data_last;
  logic       o_data_ready;
  logic       o_trans_ser;
  logic       o_crc_en;
  logic       o_done;
  logic       o_abort;

  int n_assert = 0;
  int n_fail   = 0;

  byte_q_t tx_q;
  bit      cap_q[$];

  bit r_done, r_abort, r_gap, r_fin, r_rst_hit;
  int r_viol, r_lat, r_done_rel;

  crc_16_trans dut (
    .sb_clk       (sb_clk),
    .rst          (rst),
    .i_data_in    (i_data_in),
    .i_data_valid (i_data_valid),
    .i_data_last  (i_data_last),
    .o_data_ready (o_data_ready),
    .o_trans_ser  (o_trans_ser),
    .o_crc_en     (o_crc_en),
    .o_done       (o_done),
    .o_abort      (o_abort)
  );

  always #5 sb_clk = ~sb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain software CRC-16 (poly 8005, seed FFFF, MSB-first, no final xor).
  function automatic logic [15:0] crc_ref(input byte_q_t b);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (b[i]) begin
      c = c ^ {b[i], 8'h00};
      for (int k = 0; k < 8; k++)
        c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
    end
    return c;
  endfunction

  function automatic byte_q_t pack(input bit q[$]);
    byte_q_t r;
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < q.size(); i++) begin
      v = {v[6:0], q[i]};
      if ((i % 8) == 7) r.push_back(v);
    end
    return r;
  endfunction

  // Drives tx_q through the handshake and captures every crc_en-qualified bit.
  task automatic run_frame(input int drop_after, input bit junk, input int rst_at);
    int idx, it, acc_it, en_first, en_last;
    idx = 0; it = 0; acc_it = -1; en_first = -1; en_last = -1;
    cap_q.delete();
    r_done = 0; r_abort = 0; r_gap = 0; r_fin = 0; r_rst_hit = 0;
    r_viol = 0; r_lat = -1; r_done_rel = -1;
    while (!r_fin && it < 600) begin
      @(negedge sb_clk);
      if (o_crc_en) begin
        cap_q.push_back(o_trans_ser);
        if (en_first < 0) en_first = it;
        en_last = it;
      end
      if (o_crc_en && o_data_ready && cap_q.size() >= 8 * tx_q.size()) r_viol++;
      if (o_done) r_done = 1;
      if (o_abort) r_abort = 1;
      if (o_done || o_abort) begin
        r_fin = 1;
        r_done_rel = it - en_first + 1;
      end
      if (rst_at >= 0 && cap_q.size() == rst_at && !r_rst_hit) begin
        #2 rst = 1'b0;
        r_rst_hit = 1;
        r_fin = 1;
      end
      if (r_fin) begin
        i_data_valid = 1'b0;
      end else if (idx < tx_q.size() && idx != drop_after) begin
        i_data_valid = 1'b1;
        i_data_in    = tx_q[idx];
        i_data_last  = (idx == tx_q.size() - 1);
      end else if (junk) begin
        i_data_valid = 1'b1;
        i_data_in    = 8'hA5;
        i_data_last  = 1'b1;
      end else begin
        i_data_valid = 1'b0;
        i_data_in    = 8'($urandom);
        i_data_last  = 1'b0;
      end
      if (i_data_valid && o_data_ready) begin
        if (acc_it < 0) acc_it = it;
        idx++;
      end
      it++;
    end
    i_data_valid = 1'b0;
    chk("frame_terminated", r_fin, 1);
    r_lat = en_first - acc_it;
    r_gap = ((en_last - en_first + 1) != cap_q.size());
  endtask

  task automatic check_good_frame(input string tag);
    byte_q_t pk;
    int n, mism;
    n = tx_q.size();
    pk = pack(cap_q);
    chk({tag, "_bits"}, cap_q.size(), 8 * n + 16);
    chk({tag, "_done"}, r_done, 1);
    chk({tag, "_no_abort"}, r_abort, 0);
    chk({tag, "_no_bubble"}, r_gap, 0);
    mism = 0;
    for (int i = 0; i < n && i < pk.size(); i++) if (pk[i] !== tx_q[i]) mism++;
    chk({tag, "_payload"}, mism, 0);
    if (pk.size() == n + 2) chk({tag, "_crc"}, {pk[n], pk[n+1]}, crc_ref(tx_q));
    chk({tag, "_rx_residue"}, crc_ref(pk), 0);
  endtask

  task automatic load_check_string();
    tx_q.delete();
    for (int i = 0; i < 9; i++) tx_q.push_back(8'(8'h31 + i));
  endtask

  initial begin
    bit corrupt_q[$];
    int len, pos;

    rst = 1'b1; i_data_in = 8'h00; i_data_valid = 1'b0; i_data_last = 1'b0;
    #2 rst = 1'b0;
    @(negedge sb_clk);
    @(negedge sb_clk);
    chk("rst_ready", o_data_ready, 1);
    chk("rst_ser", o_trans_ser, 0);
    chk("rst_crc_en", o_crc_en, 0);
    chk("rst_done", o_done, 0);
    chk("rst_abort", o_abort, 0);
    rst = 1'b1;

    // "123456789" reference frame
    load_check_string();
    run_frame(-1, 0, -1);
    check_good_frame("chk9");
    if (cap_q.size() == 88) chk("chk9_crc_const", {pack(cap_q)[9], pack(cap_q)[10]}, 16'hAEE7);
    chk("chk9_latency", r_lat, 2);
    chk("chk9_done_cycle", r_done_rel, 89);

    // Random loopback frames
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 16);
      tx_q.delete();
      for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
      run_frame(-1, 0, -1);
      check_good_frame("rand");
      chk("rand_done_cycle", r_done_rel, 8 * len + 17);
      if (f == 0) begin
        corrupt_q = cap_q;
        pos = $urandom_range(0, 8 * len - 1);
        corrupt_q[pos] = ~corrupt_q[pos];
        chk("rx_err_payload", crc_ref(pack(corrupt_q)) != 16'h0000, 1);
        corrupt_q = cap_q;
        pos = 8 * len + $urandom_range(0, 15);
        corrupt_q[pos] = ~corrupt_q[pos];
        chk("rx_err_crc", crc_ref(pack(corrupt_q)) != 16'h0000, 1);
      end
    end

    // Single 00h with junk valid during the CRC phase
    tx_q.delete();
    tx_q.push_back(8'h00);
    run_frame(-1, 1, -1);
    check_good_frame("zero");
    chk("zero_ready_in_crc", r_viol, 0);

    // Underrun after the first byte of a 3-byte frame
    tx_q.delete();
    for (int i = 0; i < 3; i++) tx_q.push_back(8'($urandom));
    run_frame(1, 0, -1);
    chk("underrun_abort", r_abort, 1);
    chk("underrun_no_done", r_done, 0);
    chk("underrun_bits", cap_q.size(), 8);
    chk("underrun_crc_en_low", o_crc_en, 0);

    tx_q.delete();
    for (int i = 0; i < 4; i++) tx_q.push_back(8'($urandom));
    run_frame(-1, 0, -1);
    check_good_frame("post_abort");

    // Reset in the middle of the CRC phase
    load_check_string();
    run_frame(-1, 0, 80);
    chk("rst_mid_hit", r_rst_hit, 1);
    #1;
    chk("rst_mid_ser", o_trans_ser, 0);
    chk("rst_mid_crc_en", o_crc_en, 0);
    chk("rst_mid_done", o_done, 0);
    chk("rst_mid_abort", o_abort, 0);
    chk("rst_mid_ready", o_data_ready, 1);
    @(negedge sb_clk);
    rst = 1'b1;

    load_check_string();
    run_frame(-1, 0, -1);
    check_good_frame("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_16_trans.md
# crc_16_trans

Sideband transmit-side CRC-16 serializer. It accepts a transaction as a stream of bytes over a valid/ready handshake and shifts each byte out MSB-first on `trans_ser`, one bit per `sb_clk`. It then appends the 16-bit CRC (poly 8005h, seed FFFFh, no reflection, no final XOR) MSB-first. It drives `crc_en` so that the receive-side CRC checker sees a zero residue on an error-free frame.

## Interface
- `SEED`, 16'hFFFF, LFSR initial value; must match the receiver.
- `sb_clk`  in  1  module clock; one serial bit per cycle.
- `rst`  in  1  asynchronous, active-low reset.
- `data_in`  in  8  payload byte.
- `data_valid`  in  1  `data_in` is valid.
- `data_last`  in  1  qualifies `data_in` as the final payload byte.
- `data_ready`  out  1  byte accepted when `data_valid & data_ready`.
- `trans_ser`  out  1  serial output: payload bits, then CRC bits.
- `crc_en`  out  1  high for exactly the payload bits plus the 16 CRC bits.
- `done`  out  1  one-cycle pulse; frame completed.
- `abort`  out  1  one-cycle pulse; underrun, frame dropped.

## Operation
- States:
  - IDLE: waiting for the first byte.
  - DATA: serializing payload.
  - CRC: serializing the CRC.
  - END: end-of-frame gap.
- IDLE:
  - `data_ready`=1, `crc_en`=0, `trans_ser`=0, LFSR=SEED.
  - On accept: load the shift register, latch `data_last`, set `bit_cnt`=7, go to DATA.
- DATA, each cycle:
  - Drive bit `sh[7]` on `trans_ser` with `crc_en`=1.
  - `fb = sh[7] ^ lfsr[15]`.
  - `lfsr <= {lfsr[14:3], lfsr[2]^fb... }` in the equivalent form: `lfsr[15]<=lfsr[14]^fb`, `lfsr[2]<=lfsr[1]^fb`, `lfsr[0]<=fb`, all other bits shift up by one.
  - Then shift `sh` left and decrement `bit_cnt`.
- Byte boundary (`bit_cnt`==0 in DATA):
  - `data_ready`=1 only in this cycle, so back-to-back bytes leave no bubble.
  - Latched last=1: go to CRC after this bit, with `crc_cnt`=15. `data_ready` is 0 in this cycle.
  - Latched last=0 and a byte is accepted: reload and stay in DATA.
  - Latched last=0 and no `data_valid`: underrun. Go to END with `abort`=1 and no `done`.
- CRC, each cycle:
  - `trans_ser`=`lfsr[15]`, `crc_en`=1.
  - `lfsr <= {lfsr[14:0],1'b0}`.
  - After 16 bits go to END.
- END (one cycle):
  - `crc_en`=0, `trans_ser`=0, LFSR=SEED.
  - `done`=1 for a normal frame, `abort`=1 for an underrun.
  - Then go to IDLE.
  - This guarantees at least one `crc_en`-low cycle between frames, which the receiver needs for its check.
- `data_ready` is combinational from state and `bit_cnt`. It is 0 in CRC and END.
- `data_in`/`data_last` are ignored whenever `data_ready`=0.
- Reset, asynchronous at any time, including mid-frame:
  - State goes to IDLE, LFSR to SEED, counters to 0.
  - `trans_ser`=0, `crc_en`=0, `done`=0, `abort`=0.
  - A partial frame is not resumed.

## Timing
- `trans_ser`, `crc_en`, `done`, `abort` are registered.
- Latency: byte accepted at edge T, its MSB appears on `trans_ser` after edge T+1.
- Frame of N bytes: `crc_en` is high for exactly 8N+16 consecutive cycles, then `done` follows in the first `crc_en`-low cycle.
- Minimum frame-to-frame spacing: 8N+16 bits, then 1 END cycle, then 1 IDLE accept cycle.
- LFSR update and the bit driven on `trans_ser` use the same cycle's `sh[7]`, so CRC bit k is emitted exactly one cycle after the last payload bit.

## Structure
- Shared package `usb4_sb_pkg` holds:
  - `CRC16_POLY`=16'h8005.
  - `CRC16_SEED`=16'hFFFF.
  - The tx state enum.
  - `CRC16_CHECK`=16'hAEE7, the "123456789" check value.
- One natural sub-module: `crc_16_lfsr_step`, a combinational next-LFSR function of (lfsr, bit). It is shared with the receiver for consistency.

## Test plan
- Bytes "123456789" (31h..39h), last on 39h, `data_valid` held high → 72 payload bits MSB-first, then CRC bits AEE7h (1010_1110_1110_0111), `crc_en` high 88 cycles, `done` pulse on cycle 89, no bubbles.
- Loopback into the receive-side CRC checker with random 1–16 byte frames → receiver `error`=0 after every frame.
- Same loopback, with one `trans_ser` bit inverted mid-payload, then separately one CRC bit inverted → receiver `error`=1 for both.
- Single byte 00h with last → 8 zero bits, then the CRC of 00h from the reference model; `data_ready` low during the CRC phase; `data_valid` asserted during the CRC phase is ignored.
- `data_valid` dropped at the byte boundary of a 3-byte frame (last not yet seen) → `abort` pulse, no `done`, `crc_en` falls, next frame's CRC is correct.
- `rst` asserted during the CRC phase → all outputs 0 immediately; after release, a new "123456789" frame yields AEE7h.
